fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Multi-cycle instruction-fetch sequencer for the 32-bit RISC-V core.
- Owns the program counter and drives the instruction-memory request handshake.
- Issues each fetched instruction to decode/execute, then waits for execute completion.
- Computes next PC from execute result: PC+4, taken branch, jal or jalr. Replaces the free-running PC update with a controlled one.

Parameters:
- PC_W, 10, program counter width in bits; byte address, modulo 2^PC_W.
- IMM_W, 21, immediate width; sign-extended.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- start  in  1  leave IDLE and begin fetching.
- imem_req  out  1  fetch request valid.
- imem_addr  out  PC_W  fetch address; equals pc_out.
- imem_ready  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr_valid  out  1  instruction presented to decode.
- instr  out  32  captured instruction.
- instr_pc  out  PC_W  PC of the presented instruction.
- instr_ready  in  1  decode accepts the instruction.
- exec_done  in  1  execute finished the current instruction.
- branch  in  1  redirect request, sampled with exec_done.
- zero_flag  in  1  branch condition, sampled with exec_done.
- mem_to_reg  in  2  redirect kind: 10 = jal, 11 = jalr, others = conditional branch.
- immediate  in  IMM_W  offset.
- reg_out1  in  32  rs1 value, used for jalr.
- halt_req  in  1  stop after current instruction (ecall/ebreak), sampled with exec_done.
- pc_out  out  PC_W  architectural PC.
- halted  out  1  controller is in HALT.
- misalign  out  1  halt was caused by a misaligned target.

Behaviour:
- States: IDLE, FETCH, ISSUE, EXEC, HALT.
- Reset (async, reset=0):
  - state=IDLE, pc_out=RESET_PC.
  - instr=0, instr_pc=0.
  - imem_req=0, instr_valid=0, halted=0, misalign=0.
- IDLE:
  - All handshake outputs 0.
  - start=1 -> FETCH next cycle.
- FETCH:
  - imem_req=1, imem_addr=pc_out.
  - imem_ready=1 -> capture instr=imem_rdata, instr_pc=pc_out, go ISSUE.
  - imem_req stays high until imem_ready is seen.
- ISSUE:
  - instr_valid=1; instr and instr_pc held stable.
  - instr_ready=1 -> EXEC.
  - instr_valid deasserts the cycle after acceptance.
- EXEC:
  - Wait for exec_done. On exec_done compute target T (mod 2^PC_W, immediate sign-extended):
    - branch=0, or conditional branch with zero_flag=0: T = instr_pc + 4.
    - branch=1, mem_to_reg=10: T = instr_pc + imm.
    - branch=1, mem_to_reg=11: T = (reg_out1[PC_W-1:0] + imm) with bit0 cleared.
    - branch=1, other mem_to_reg, zero_flag=1: T = instr_pc + imm.
  - Then:
    - T[1]=1 -> HALT, misalign=1, pc_out unchanged.
    - Else halt_req=1 -> pc_out=T, HALT, misalign=0.
    - Else pc_out=T, go FETCH.
  - branch/zero_flag/mem_to_reg/halt_req ignored when exec_done=0.
- HALT:
  - halted=1; all requests 0.
  - Sticky until reset; start is ignored.
- Latency:
  - Zero-wait memory and decode, exec_done in first EXEC cycle: 3 cycles per instruction.
  - Fetch-to-fetch spacing is 3 cycles.
- Wrap-around: pc_out = 2^PC_W-4 with no redirect -> 0; no flag.
- imem_ready outside FETCH, or instr_ready outside ISSUE: ignored.
- Reset asserted mid-FETCH or mid-ISSUE: outstanding request abandoned. After release, state=IDLE and a late imem_ready is ignored.
- Only pc_out and the captured instr/instr_pc are registered state; imem_addr and handshake outputs decode from state.

Decomposition:
- Shared package (core_pkg):
  - State encoding localparams.
  - mem_to_reg kind constants (JAL=2'b10, JALR=2'b11).
  - INSTR_BYTES=4.
- One sub-module: next_pc_calc, a combinational target and misalign computation.
  - Inputs: instr_pc, branch, zero_flag, mem_to_reg, immediate, reg_out1.
  - Outputs: T, misaligned.
- The FSM and registers stay in fetch_ctrl.

Test Plan:
- Reset with reset=0, release, pulse start; imem_ready, instr_ready, exec_done tied 1 with branch=0 -> imem_addr sequence 0, 4, 8, one fetch every 3 cycles.
- At instr_pc=8: branch=1, mem_to_reg=00, zero_flag=1, immediate=196 -> pc_out=204. Same with zero_flag=0 -> pc_out=12.
- At instr_pc=204: mem_to_reg=10, immediate=800 -> pc_out=(1004) mod 1024=1004. Next sequential fetch at 1008. Then from 1020 with no redirect -> pc_out=0.
- jalr: reg_out1=15, immediate=20 -> T=34 (bit1 set) -> halted=1, misalign=1, pc_out unchanged. reg_out1=17, immediate=20 -> pc_out=36.
- Stalls: imem_ready low 3 cycles in FETCH -> imem_req held high with stable addr. instr_ready low 2 cycles -> instr_valid held, instr stable.
- Reset mid-FETCH (reset=0 for 1 cycle while imem_req=1) -> all outputs at reset values immediately, state IDLE, subsequent imem_ready ignored. halt_req=1 with exec_done at instr_pc=4 -> pc_out=8, halted=1, no further imem_req.

Source files
------------

// File: rtl/core_pkg.sv
// Shared encodings for the fetch sequencer: FSM states, redirect kinds, instruction size.
// Pure declarations: no logic, no latency, no flow control.
package core_pkg;

    localparam int INSTR_BYTES = 4;

    // mem_to_reg doubles as the redirect kind when branch is asserted
    localparam logic [1:0] M2R_JAL  = 2'b10;
    localparam logic [1:0] M2R_JALR = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_EXEC  = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_FETCH = ST_FETCH,
        S_ISSUE = ST_ISSUE,
        S_EXEC  = ST_EXEC,
        S_HALT  = ST_HALT
    } state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundles the instruction-memory, decode-issue and execute-result signals of the fetch sequencer.
// Wires only; master is the sequencer side, slave is the memory/decode/execute side.
interface fetch_ctrl_if #(
    parameter int PC_W  = 10,
    parameter int IMM_W = 21
);

    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic             imem_ready;
    logic [31:0]      imem_rdata;

    logic             instr_valid;
    logic [31:0]      instr;
    logic [PC_W-1:0]  instr_pc;
    logic             instr_ready;

    logic             exec_done;
    logic             branch;
    logic             zero_flag;
    logic [1:0]       mem_to_reg;
    logic [IMM_W-1:0] immediate;
    logic [31:0]      reg_out1;
    logic             halt_req;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ready, imem_rdata, instr_ready,
        input  exec_done, branch, zero_flag, mem_to_reg, immediate, reg_out1, halt_req
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ready, imem_rdata, instr_ready,
        output exec_done, branch, zero_flag, mem_to_reg, immediate, reg_out1, halt_req
    );

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC target (sequential, branch, jal, jalr) and misalignment flag.
// Zero latency; no flow control, the caller decides when the result is used.
module next_pc_calc
    import core_pkg::*;
#(
    parameter int PC_W  = 10,
    parameter int IMM_W = 21
) (
    input  logic [PC_W-1:0]  instr_pc,
    input  logic             branch,
    input  logic             zero_flag,
    input  logic [1:0]       mem_to_reg,
    input  logic [IMM_W-1:0] immediate,
    input  logic [31:0]      reg_out1,
    output logic [PC_W-1:0]  target,
    output logic             misaligned
);

    logic [IMM_W+PC_W-1:0] imm_wide;
    logic [PC_W-1:0]       imm_ext;
    logic [PC_W-1:0]       seq_pc;
    logic [PC_W-1:0]       rel_pc;
    logic [PC_W-1:0]       reg_pc;
    logic                  unused_hi;

    always_comb begin
        // sign-extend past PC_W, then keep the low PC_W bits: arithmetic is mod 2^PC_W
        imm_wide = {{PC_W{immediate[IMM_W-1]}}, immediate};
        imm_ext  = imm_wide[PC_W-1:0];
        seq_pc   = instr_pc + PC_W'(INSTR_BYTES);
        rel_pc   = instr_pc + imm_ext;
        reg_pc   = reg_out1[PC_W-1:0] + imm_ext;
        reg_pc[0] = 1'b0;

        target = seq_pc;
        if (branch) begin
            if (mem_to_reg == M2R_JALR) begin
                target = reg_pc;
            end else if (mem_to_reg == M2R_JAL || zero_flag) begin
                target = rel_pc;
            end
        end
        misaligned = target[1];
    end

    assign unused_hi = ^{imm_wide[IMM_W+PC_W-1:PC_W], reg_out1[31:PC_W]};

endmodule

// File: rtl/fetch_ctrl.sv
// Multi-cycle fetch sequencer: owns the PC, fetches, issues, waits for execute, redirects.
// 3 cycles/instruction with zero-wait peers; stalls in FETCH/ISSUE/EXEC until ready/done.
module fetch_ctrl
    import core_pkg::*;
#(
    parameter int              PC_W     = 10,
    parameter int              IMM_W    = 21,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    fetch_ctrl_if.master    bus,
    output logic [PC_W-1:0] pc_out,
    output logic            halted,
    output logic            misalign
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] instr_pc_q, instr_pc_d;
    logic            misalign_q, misalign_d;

    logic            imem_req_c;
    logic            instr_valid_c;
    logic            halted_c;

    logic [PC_W-1:0] target;
    logic            target_mis;

    next_pc_calc #(
        .PC_W  (PC_W),
        .IMM_W (IMM_W)
    ) u_next_pc (
        .instr_pc   (instr_pc_q),
        .branch     (bus.branch),
        .zero_flag  (bus.zero_flag),
        .mem_to_reg (bus.mem_to_reg),
        .immediate  (bus.immediate),
        .reg_out1   (bus.reg_out1),
        .target     (target),
        .misaligned (target_mis)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        misalign_d    = misalign_q;
        imem_req_c    = 1'b0;
        instr_valid_c = 1'b0;
        halted_c      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ready) begin
                    instr_d    = bus.imem_rdata;
                    instr_pc_d = pc_q;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                instr_valid_c = 1'b1;
                if (bus.instr_ready) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (bus.exec_done) begin
                    // a misaligned target halts without committing it, so pc_out names the faulting instruction
                    if (target_mis) begin
                        misalign_d = 1'b1;
                        state_d    = S_HALT;
                    end else begin
                        pc_d    = target;
                        state_d = bus.halt_req ? S_HALT : S_FETCH;
                    end
                end
            end
            S_HALT: begin
                halted_c = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.imem_req    = imem_req_c;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = instr_valid_c;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;

    assign pc_out   = pc_q;
    assign halted   = halted_c;
    assign misalign = misalign_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a vector table of whole instructions plus hand-written stall/reset/halt sequences.
module tb_fetch_ctrl;

    localparam int PC_W  = 10;
    localparam int IMM_W = 21;

    typedef struct {
        logic [PC_W-1:0]  pc;
        logic             br;
        logic             z;
        logic [1:0]       m2r;
        logic [IMM_W-1:0] imm;
        logic [31:0]      r1;
        logic             hr;
        logic [PC_W-1:0]  exp_pc;
        logic             exp_halt;
        logic             exp_mis;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [PC_W-1:0] pc_out;
    logic            halted;
    logic            misalign;

    int checks = 0;
    int errors = 0;

    vec_t vecs [11];

    fetch_ctrl_if #(.PC_W(PC_W), .IMM_W(IMM_W)) bus ();

    fetch_ctrl #(
        .PC_W     (PC_W),
        .IMM_W    (IMM_W),
        .RESET_PC (10'd0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bus      (bus),
        .pc_out   (pc_out),
        .halted   (halted),
        .misalign (misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [PC_W-1:0] a);
        return 32'hA5A5_0000 | {22'd0, a};
    endfunction

    function automatic vec_t mk(input logic [PC_W-1:0] pc, input logic br, input logic z,
                                input logic [1:0] m2r, input logic [IMM_W-1:0] imm,
                                input logic [31:0] r1, input logic hr, input logic [PC_W-1:0] exp_pc,
                                input logic exp_halt, input logic exp_mis);
        vec_t v;
        v.pc = pc; v.br = br; v.z = z; v.m2r = m2r; v.imm = imm; v.r1 = r1; v.hr = hr;
        v.exp_pc = exp_pc; v.exp_halt = exp_halt; v.exp_mis = exp_mis;
        return v;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.imem_ready  = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.instr_ready = 1'b0;
        bus.exec_done   = 1'b0;
        bus.branch      = 1'b0;
        bus.zero_flag   = 1'b0;
        bus.mem_to_reg  = 2'b00;
        bus.immediate   = '0;
        bus.reg_out1    = 32'h0;
        bus.halt_req    = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        start = 1'b0;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    // Carries one instruction through FETCH, ISSUE and EXEC with zero-wait peers,
    // plus one EXEC cycle of decoy redirect inputs while exec_done is low.
    task automatic run_vec(input vec_t v, input string tag);
        int n = 0;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk($sformatf("%s.req", tag), 32'(bus.imem_req), 32'd1);
        if (bus.imem_req !== 1'b1) return;
        chk($sformatf("%s.addr", tag), 32'(bus.imem_addr), 32'(v.pc));
        bus.imem_rdata = word_at(v.pc);
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready = 1'b0;

        chk($sformatf("%s.valid", tag), 32'(bus.instr_valid), 32'd1);
        chk($sformatf("%s.instr", tag), bus.instr, word_at(v.pc));
        chk($sformatf("%s.instr_pc", tag), 32'(bus.instr_pc), 32'(v.pc));
        chk($sformatf("%s.req_issue", tag), 32'(bus.imem_req), 32'd0);
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;

        chk($sformatf("%s.valid_off", tag), 32'(bus.instr_valid), 32'd0);
        bus.branch = 1'b1; bus.mem_to_reg = 2'b10; bus.immediate = 21'd64;
        bus.zero_flag = 1'b1; bus.halt_req = 1'b1;
        bus.imem_ready = 1'b1; bus.instr_ready = 1'b1;
        step();
        chk($sformatf("%s.wait_pc", tag), 32'(pc_out), 32'(v.pc));
        chk($sformatf("%s.wait_halt", tag), 32'(halted), 32'd0);
        chk($sformatf("%s.wait_req", tag), 32'(bus.imem_req), 32'd0);

        bus.imem_ready = 1'b0; bus.instr_ready = 1'b0;
        bus.exec_done = 1'b1;
        bus.branch = v.br; bus.zero_flag = v.z; bus.mem_to_reg = v.m2r;
        bus.immediate = v.imm; bus.reg_out1 = v.r1; bus.halt_req = v.hr;
        step();
        clear_inputs();
        chk($sformatf("%s.pc_out", tag), 32'(pc_out), 32'(v.exp_pc));
        chk($sformatf("%s.halted", tag), 32'(halted), 32'(v.exp_halt));
        chk($sformatf("%s.misalign", tag), 32'(misalign), 32'(v.exp_mis));
    endtask

    initial begin
        //              pc    br    z     m2r    imm            r1     hr    exp_pc halt  mis
        vecs[0]  = mk(10'd0,    1'b0, 1'b0, 2'b00, 21'd0,        32'd0,  1'b0, 10'd4,    1'b0, 1'b0);
        vecs[1]  = mk(10'd4,    1'b1, 1'b0, 2'b01, 21'd100,      32'd0,  1'b0, 10'd8,    1'b0, 1'b0);
        vecs[2]  = mk(10'd8,    1'b1, 1'b0, 2'b00, 21'd196,      32'd0,  1'b0, 10'd12,   1'b0, 1'b0);
        vecs[3]  = mk(10'd12,   1'b1, 1'b0, 2'b10, 21'h1FFFFC,   32'd0,  1'b0, 10'd8,    1'b0, 1'b0);
        vecs[4]  = mk(10'd8,    1'b1, 1'b1, 2'b00, 21'd196,      32'd0,  1'b0, 10'd204,  1'b0, 1'b0);
        vecs[5]  = mk(10'd204,  1'b1, 1'b0, 2'b10, 21'd800,      32'd0,  1'b0, 10'd1004, 1'b0, 1'b0);
        vecs[6]  = mk(10'd1004, 1'b0, 1'b0, 2'b00, 21'd0,        32'd0,  1'b0, 10'd1008, 1'b0, 1'b0);
        vecs[7]  = mk(10'd1008, 1'b1, 1'b0, 2'b10, 21'd12,       32'd0,  1'b0, 10'd1020, 1'b0, 1'b0);
        vecs[8]  = mk(10'd1020, 1'b0, 1'b0, 2'b00, 21'd0,        32'd0,  1'b0, 10'd0,    1'b0, 1'b0);
        vecs[9]  = mk(10'd0,    1'b1, 1'b0, 2'b11, 21'd20,       32'd17, 1'b0, 10'd36,   1'b0, 1'b0);
        vecs[10] = mk(10'd36,   1'b1, 1'b0, 2'b11, 21'd20,       32'd15, 1'b0, 10'd36,   1'b1, 1'b1);

        // reset values while reset is held low
        clear_inputs();
        #12;
        chk("rst.pc_out", 32'(pc_out), 32'd0);
        chk("rst.instr", bus.instr, 32'd0);
        chk("rst.instr_pc", 32'(bus.instr_pc), 32'd0);
        chk("rst.imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst.instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst.halted", 32'(halted), 32'd0);
        chk("rst.misalign", 32'(misalign), 32'd0);
        reset = 1'b1;
        step();
        bus.imem_ready = 1'b1;
        step();
        step();
        chk("idle.req", 32'(bus.imem_req), 32'd0);
        chk("idle.instr", bus.instr, 32'd0);
        clear_inputs();

        // table: sequential, branches, jal wrap, jalr, misaligned jalr halt
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // HALT is sticky and ignores start
        start = 1'b1;
        bus.imem_ready = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("halt.req", 32'(bus.imem_req), 32'd0);
            chk("halt.halted", 32'(halted), 32'd1);
        end
        chk("halt.pc", 32'(pc_out), 32'd36);
        clear_inputs();

        // fetch-to-fetch spacing with everything tied ready
        do_reset();
        chk("c.halted_cleared", 32'(halted), 32'd0);
        chk("c.mis_cleared", 32'(misalign), 32'd0);
        bus.imem_ready = 1'b1; bus.instr_ready = 1'b1; bus.exec_done = 1'b1;
        bus.imem_rdata = 32'h0000_0013;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i % 3 == 0) begin
                chk($sformatf("c.req%0d", i), 32'(bus.imem_req), 32'd1);
                chk($sformatf("c.addr%0d", i), 32'(bus.imem_addr), 32'(4 * (i / 3)));
            end else begin
                chk($sformatf("c.req%0d", i), 32'(bus.imem_req), 32'd0);
            end
            step();
        end
        clear_inputs();

        // stalls in FETCH and ISSUE, then halt_req at pc 4
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        bus.imem_rdata = word_at(10'd0);
        for (int k = 0; k < 3; k++) begin
            chk("d.req_stall", 32'(bus.imem_req), 32'd1);
            chk("d.addr_stall", 32'(bus.imem_addr), 32'd0);
            step();
        end
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 2; k++) begin
            chk("d.valid_stall", 32'(bus.instr_valid), 32'd1);
            chk("d.instr_stall", bus.instr, word_at(10'd0));
            step();
        end
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        chk("d.valid_after", 32'(bus.instr_valid), 32'd0);
        bus.exec_done = 1'b1;
        step();
        bus.exec_done = 1'b0;
        chk("d.pc4", 32'(pc_out), 32'd4);
        clear_inputs();
        run_vec(mk(10'd4, 1'b0, 1'b0, 2'b00, 21'd0, 32'd0, 1'b1, 10'd8, 1'b1, 1'b0), "d.halt");
        bus.imem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("d.no_req", 32'(bus.imem_req), 32'd0);
        end
        clear_inputs();

        // reset while FETCH is outstanding at pc 4
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        run_vec(vecs[0], "e.first");
        chk("e.req_pre", 32'(bus.imem_req), 32'd1);
        chk("e.addr_pre", 32'(bus.imem_addr), 32'd4);
        reset = 1'b0;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("e.req_rst", 32'(bus.imem_req), 32'd0);
        chk("e.pc_rst", 32'(pc_out), 32'd0);
        chk("e.instr_rst", bus.instr, 32'd0);
        chk("e.instr_pc_rst", 32'(bus.instr_pc), 32'd0);
        step();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("e.req_late", 32'(bus.imem_req), 32'd0);
            chk("e.instr_late", bus.instr, 32'd0);
            chk("e.valid_late", 32'(bus.instr_valid), 32'd0);
        end
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
